// File: rtl/abus_pkg.sv
// Shared types and constants for the abus copy engine.
package abus_pkg;

  localparam int unsigned STATUS_W = 2;

  localparam logic [STATUS_W-1:0] ST_OK     = 2'b00;
  localparam logic [STATUS_W-1:0] ST_BUSERR = 2'b01;
  localparam logic [STATUS_W-1:0] ST_CANCEL = 2'b10;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_RD_REQ,
    DMA_RD_WAIT,
    DMA_WR_REQ,
    DMA_WR_WAIT,
    DMA_CANCEL,
    DMA_FINISH
  } dma_state_t;

  // Width of the strobe/keep fields for a given data width.
  function automatic int unsigned sk_size(input int unsigned data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/abus_dma_fifo.sv
// Synchronous burst buffer between the read and write phases of a copy.
module abus_dma_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_c_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, empty_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  // Occupancy after this cycle's push/pop/flush.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) cnt_d = '0;
    else         cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end

  // Pointers, count and registered full/empty flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_c_o = mem_q[rd_ptr_q];
  assign full_o   = full_q;
  assign empty_o  = empty_q;

endmodule

// File: rtl/abus_dma.sv
// Single-channel memory-to-memory copy engine driving one abus master order port.
module abus_dma
  import abus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned SK_SIZE   = sk_size(DATA_WIDTH)
) (
  input  logic                  abus_clk,
  input  logic                  abus_rstb,
  input  logic                  start,
  input  logic                  cancel,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  irq,
  output logic [STATUS_W-1:0]   status,
  output logic [LEN_WIDTH-1:0]  remaining,
  output logic                  write,
  output logic                  read,
  output logic                  abort,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [SK_SIZE-1:0]    strb,
  output logic [SK_SIZE-1:0]    keep,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  new_rdata,
  input  logic                  done,
  input  logic                  err
);

  localparam int unsigned BW = $clog2(FIFO_DEPTH + 1);

  dma_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, address_q, address_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic [STATUS_W-1:0]   status_q, status_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, fifo_head;
  logic busy_q, busy_d, irq_q, irq_d;
  logic read_q, read_d, write_q, write_d, abort_q, abort_d;
  logic push_c, pop_c, flush_c, fifo_full, fifo_empty;
  logic rd_last_c, wr_last_c, rem_last_c;

  // Burst ends at min(FIFO_DEPTH, words still to write); write phase ends when the buffer drains.
  assign rd_last_c  = (32'(burst_q) + 32'd1 == FIFO_DEPTH) ||
                      (32'(burst_q) + 32'd1 == 32'(rem_q));
  assign wr_last_c  = (burst_q == BW'(1));
  assign rem_last_c = (rem_q == LEN_WIDTH'(1));

  // State register.
  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) state_q <= DMA_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DMA_IDLE:    if (start) state_d = (length == '0) ? DMA_FINISH : DMA_RD_REQ;
      DMA_RD_REQ:  state_d = cancel ? DMA_FINISH : DMA_RD_WAIT;
      DMA_RD_WAIT: begin
        if (done) begin
          if (cancel || err) state_d = DMA_FINISH;
          else if (rd_last_c) state_d = DMA_WR_REQ;
          else state_d = DMA_RD_REQ;
        end else if (cancel) begin
          state_d = DMA_CANCEL;
        end
      end
      DMA_WR_REQ:  state_d = cancel ? DMA_FINISH : DMA_WR_WAIT;
      DMA_WR_WAIT: begin
        if (done) begin
          if (cancel || err) state_d = DMA_FINISH;
          else if (wr_last_c) state_d = rem_last_c ? DMA_FINISH : DMA_RD_REQ;
          else state_d = DMA_WR_REQ;
        end else if (cancel) begin
          state_d = DMA_CANCEL;
        end
      end
      DMA_CANCEL:  if (done) state_d = DMA_FINISH;
      DMA_FINISH:  state_d = DMA_IDLE;
      default:     state_d = DMA_IDLE;
    endcase
  end

  // Output and datapath next values; orders are registered so they pulse the cycle after *_REQ.
  always_comb begin
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    burst_d   = burst_q;
    busy_d    = busy_q;
    status_d  = status_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    irq_d     = 1'b0;
    read_d    = 1'b0;
    write_d   = 1'b0;
    abort_d   = 1'b0;
    push_c    = 1'b0;
    pop_c     = 1'b0;
    flush_c   = 1'b0;
    unique case (state_q)
      DMA_IDLE: begin
        if (start) begin
          src_d    = src_addr;
          dst_d    = dst_addr;
          rem_d    = length;
          burst_d  = '0;
          busy_d   = 1'b1;
          status_d = ST_OK;
        end
      end
      DMA_RD_REQ: begin
        if (cancel) begin
          status_d = ST_CANCEL;
        end else begin
          read_d    = 1'b1;
          address_d = src_q;
        end
      end
      DMA_RD_WAIT: begin
        push_c = new_rdata;
        if (done) begin
          src_d   = src_q + ADDR_WIDTH'(1);
          burst_d = burst_q + BW'(1);
          if (cancel)   status_d = ST_CANCEL;
          else if (err) status_d = ST_BUSERR;
        end else if (cancel) begin
          abort_d  = 1'b1;
          status_d = ST_CANCEL;
        end
      end
      DMA_WR_REQ: begin
        if (cancel) begin
          status_d = ST_CANCEL;
        end else begin
          write_d   = 1'b1;
          address_d = dst_q;
          wdata_d   = fifo_head;
        end
      end
      DMA_WR_WAIT: begin
        if (done) begin
          if (!err) begin
            pop_c   = 1'b1;
            dst_d   = dst_q + ADDR_WIDTH'(1);
            rem_d   = rem_q - LEN_WIDTH'(1);
            burst_d = burst_q - BW'(1);
          end
          if (cancel)   status_d = ST_CANCEL;
          else if (err) status_d = ST_BUSERR;
        end else if (cancel) begin
          abort_d  = 1'b1;
          status_d = ST_CANCEL;
        end
      end
      DMA_FINISH: begin
        irq_d   = 1'b1;
        busy_d  = 1'b0;
        flush_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      burst_q   <= '0;
      busy_q    <= 1'b0;
      irq_q     <= 1'b0;
      status_q  <= ST_OK;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      abort_q   <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      burst_q   <= burst_d;
      busy_q    <= busy_d;
      irq_q     <= irq_d;
      status_q  <= status_d;
      read_q    <= read_d;
      write_q   <= write_d;
      abort_q   <= abort_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
    end
  end

  abus_dma_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk      (abus_clk),
    .rst_n    (abus_rstb),
    .push_i   (push_c),
    .pop_i    (pop_c),
    .flush_i  (flush_c),
    .wdata_i  (rdata),
    .head_c_o (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // The burst sizing keeps the buffer in range; anything else is a design bug.
  assert property (@(posedge abus_clk) disable iff (!abus_rstb) !(push_c && fifo_full));
  assert property (@(posedge abus_clk) disable iff (!abus_rstb) !(pop_c && fifo_empty));

  assign busy      = busy_q;
  assign irq       = irq_q;
  assign status    = status_q;
  assign remaining = rem_q;
  assign read      = read_q;
  assign write     = write_q;
  assign abort     = abort_q;
  assign address   = address_q;
  assign wdata     = wdata_q;
  assign strb      = '0;
  assign keep      = '1;

endmodule
